tic_tac_move_entry: RTL
=======================

# tic_tac_move_entry

Upstream front end for the tic-tac-toe computer-player FSM. It synchronizes the raw switch/button entry from the board and tracks occupancy of all nine squares for both players. It rejects illegal human moves and presents each accepted move to the FSM as a one-cycle `hMoveValid` strobe. It records the FSM's reply in the occupancy map and flags game-over on a computer win or a full board.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizer on `sw` and `enter`; legal range 2–3.
- `COMP_FIRST_SQ`, default 5: square the computer holds out of reset, its opening move; range 1–9.

Ports:
- `clock`, input, 1: system clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high.
- `sw`, input, 4: raw human square select, asynchronous; squares encoded 1–9, 0 means no square.
- `enter`, input, 1: raw human commit button, asynchronous, active-high.
- `cMove`, input, 4: computer's reply square from the FSM, valid in `WAIT_C`.
- `win`, input, 1: computer-win flag from the FSM, valid in `WAIT_C`.
- `hMove`, output, 4: registered accepted human square; the FSM steps only in cycles where `hMoveValid` is 1.
- `hMoveValid`, output, 1: one-cycle strobe meaning `hMove` is new.
- `illegal`, output, 1: one-cycle pulse when an entry is rejected.
- `humanBoard`, output, 9: occupancy bitmap; bit i-1 corresponds to square i.
- `compBoard`, output, 9: occupancy bitmap; bit i-1 corresponds to square i.
- `gameOver`, output, 1: level signal, asserted in `DONE`.
- `compWon`, output, 1: level signal, valid while `gameOver` is 1.
- `draw`, output, 1: level signal, valid while `gameOver` is 1.

## Operation
- Input conditioning: `sw` and `enter` each pass through a `SYNC_STAGES` flip-flop synchronizer. A rising-edge detect on the synchronized `enter` produces `entPulse`, at most one pulse per press.
- States:
  - `IDLE`: waiting for a human entry.
  - `ISSUE`: `hMoveValid` = 1.
  - `WAIT_C`: capturing the computer's reply.
  - `DONE`: game over.
- `IDLE` with `entPulse` asserted, using the synchronized `sw` value s:
  - Legal means 1 ≤ s ≤ 9 and bit s-1 is clear in both `humanBoard` and `compBoard`.
  - Legal entry: `hMove` <= s, go to `ISSUE`.
  - Illegal entry: `illegal` pulses the next cycle, state remains `IDLE`, boards unchanged.
- `ISSUE`, one cycle:
  - `hMoveValid` = 1; set `humanBoard` bit s-1.
  - If `humanBoard` and `compBoard` together then cover all nine squares, go to `DONE` with `draw` = 1.
  - Otherwise go to `WAIT_C`.
- `WAIT_C`, one cycle:
  - If `cMove` is in 1–9 and free, set `compBoard` bit `cMove`-1. An out-of-range or occupied `cMove` is ignored and leaves the boards unchanged.
  - If `win` = 1, go to `DONE` with `compWon` = 1.
  - Else if the board is now full, go to `DONE` with `draw` = 1.
  - Else go to `IDLE`.
- `DONE`: absorbing state. `entPulse` is ignored, with no `illegal` pulse. The block leaves only on `reset`.
- Human-win detection is not part of this block; the FSM's policy never permits it.
- An `entPulse` arriving in `ISSUE`, `WAIT_C` or `DONE` is dropped and not queued.

## Timing
- Reset values:
  - State `IDLE`; `hMove` = 0; `hMoveValid` = 0; `illegal` = 0.
  - `humanBoard` = 0.
  - `compBoard` = one-hot bit `COMP_FIRST_SQ`-1, i.e. 9'b000010000 at the default.
  - `gameOver`, `compWon`, `draw` = 0.
  - Synchronizer and edge-detect flops = 0.
- Latency:
  - Raw `enter` rise to `entPulse`: `SYNC_STAGES`+1 cycles.
  - `entPulse` at cycle E gives `hMoveValid` or `illegal` at E+1, and `humanBoard` updated and visible at E+2.
  - `WAIT_C` occupies E+2; `compBoard`, `gameOver`, `compWon` and `draw` are visible at E+3.
- `hMoveValid` is never high in two consecutive cycles; the minimum spacing between strobes is 3 cycles.
- `reset` mid-game, in any state, returns all outputs to their reset values on the next edge and drops any pending entry.
- `enter` held high produces only one `entPulse`; a re-press requires `enter` low for at least one synchronized cycle.

## Structure
- Package `tic_tac_pkg` holds:
  - The state enum `entry_state_t` with `IDLE`, `ISSUE`, `WAIT_C`, `DONE`.
  - `NUM_SQ` = 9.
  - `NO_MOVE` = 4'd0.
  - A function `sq_onehot(logic [3:0])` returning 9 bits, 0 for out-of-range input.
- Sub-module `tic_tac_sync_edge`: the parameterized synchronizer plus rising-edge pulse, instantiated for `enter`. Its synchronizer chain is reused, without the edge detect, for the 4-bit `sw` bus.
- Board registers and the next-state/output logic stay in the top module.

## Test plan
- Reset check: after reset, `compBoard` = 9'h010, `humanBoard` = 0, and all flags are 0. Press `enter` with `sw` = 1 → `hMoveValid` pulses exactly 1 cycle with `hMove` = 1, then `humanBoard` = 9'h001.
- Occupied square: press with `sw` = 5 (the computer's centre) → `illegal` pulses 1 cycle, no `hMoveValid`, boards unchanged.
- Out of range: press with `sw` = 0 and then `sw` = 10 → `illegal` pulses each time, state stays `IDLE`.
- Computer reply: drive `cMove` = 9 and `win` = 0 in `WAIT_C` → `compBoard` = 9'h110 and state returns to `IDLE`. Next round with `win` = 1 → `gameOver` = 1, `compWon` = 1, and further presses produce neither `hMoveValid` nor `illegal`.
- Draw: fill all squares alternately without `win` → `draw` = 1 after the move that fills the final square.
- Robustness:
  - Holding `enter` high for 20 cycles → exactly one `hMoveValid`.
  - Asserting `reset` during `WAIT_C` → all outputs return to reset values on the next edge.
  - A glitching `sw` that settles before the sync stages → the settled value is used.

Source files
------------

// File: rtl/tic_tac_move_entry_pkg.sv
// =============================================================================
// tic_tac_pkg : shared types and helpers for the tic-tac-toe move-entry block
// Revision    : 1.0
// =============================================================================
`default_nettype none

package tic_tac_pkg;

  localparam int         NUM_SQ  = 9;
  localparam logic [3:0] NO_MOVE = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_C = 2'd2,
    DONE   = 2'd3
  } entry_state_t;

  // Squares are numbered 1..9; anything else maps to an empty bitmap.
  function automatic logic [NUM_SQ-1:0] sq_onehot(input logic [3:0] sq);
    sq_onehot = '0;
    if (sq >= 4'd1 && sq <= 4'd9) begin
      sq_onehot = {{(NUM_SQ-1){1'b0}}, 1'b1} << (sq - 4'd1);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/tic_tac_move_entry_if.sv
// =============================================================================
// tic_tac_move_entry_if : board-entry / FSM handshake bundle
// Revision              : 1.0
// =============================================================================
`default_nettype none

interface tic_tac_move_entry_if;
  import tic_tac_pkg::*;

  logic [3:0]        sw;
  logic              enter;
  logic [3:0]        cMove;
  logic              win;
  logic [3:0]        hMove;
  logic              hMoveValid;
  logic              illegal;
  logic [NUM_SQ-1:0] humanBoard;
  logic [NUM_SQ-1:0] compBoard;
  logic              gameOver;
  logic              compWon;
  logic              draw;

  // master: switches/buttons and the player FSM; slave: the entry block
  modport master (
    output sw, enter, cMove, win,
    input  hMove, hMoveValid, illegal, humanBoard, compBoard,
           gameOver, compWon, draw
  );

  modport slave (
    input  sw, enter, cMove, win,
    output hMove, hMoveValid, illegal, humanBoard, compBoard,
           gameOver, compWon, draw
  );

endinterface

`default_nettype wire

// File: rtl/tic_tac_move_entry_sync_edge.sv
// =============================================================================
// tic_tac_sync_chain / tic_tac_sync_edge : multi-flop synchronizer, and the
// same chain followed by a registered rising-edge pulse.   Revision : 1.0
// =============================================================================
`default_nettype none

module tic_tac_sync_chain #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] async_in,
  output logic      [WIDTH-1:0] sync_out
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

module tic_tac_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic async_in,
  output logic      rise_pulse
);

  logic sync_lvl;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  tic_tac_sync_chain #(
    .WIDTH       (1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chain (
    .clock    (clock),
    .reset    (reset),
    .async_in (async_in),
    .sync_out (sync_lvl)
  );

  // Pulse is registered so a press costs SYNC_STAGES+1 cycles end to end.
  always_comb begin
    prev_d  = sync_lvl;
    pulse_d = sync_lvl & ~prev_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign rise_pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/tic_tac_move_entry.sv
// =============================================================================
// tic_tac_move_entry : synchronizes human entry, tracks both boards, screens
// illegal moves and records the computer's reply.          Revision : 1.0
// =============================================================================
`default_nettype none

module tic_tac_move_entry
  import tic_tac_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int COMP_FIRST_SQ = 5
) (
  input wire logic            clock,
  input wire logic            reset,
  tic_tac_move_entry_if.slave bus
);

  localparam logic [NUM_SQ-1:0] COMP_INIT  = sq_onehot(4'(COMP_FIRST_SQ));
  localparam logic [NUM_SQ-1:0] FULL_BOARD = '1;

  logic [3:0] sw_sync;
  logic       ent_pulse;

  entry_state_t      state_q,       state_d;
  logic [3:0]        hmove_q,       hmove_d;
  logic              hmove_valid_q, hmove_valid_d;
  logic              illegal_q,     illegal_d;
  logic [NUM_SQ-1:0] human_q,       human_d;
  logic [NUM_SQ-1:0] comp_q,        comp_d;
  logic              game_over_q,   game_over_d;
  logic              comp_won_q,    comp_won_d;
  logic              draw_q,        draw_d;

  logic [NUM_SQ-1:0] sw_oh;
  logic [NUM_SQ-1:0] cmove_oh;
  logic [NUM_SQ-1:0] taken;

  tic_tac_sync_chain #(
    .WIDTH       (4),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.sw),
    .sync_out (sw_sync)
  );

  tic_tac_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_enter_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (bus.enter),
    .rise_pulse (ent_pulse)
  );

  always_comb begin
    state_d       = state_q;
    hmove_d       = hmove_q;
    hmove_valid_d = 1'b0;
    illegal_d     = 1'b0;
    human_d       = human_q;
    comp_d        = comp_q;
    game_over_d   = game_over_q;
    comp_won_d    = comp_won_q;
    draw_d        = draw_q;

    sw_oh    = sq_onehot(sw_sync);
    cmove_oh = sq_onehot(bus.cMove);
    taken    = human_q | comp_q;

    case (state_q)
      IDLE: begin
        // An empty one-hot means out of range, so legality is one test.
        if (ent_pulse) begin
          if ((sw_oh != '0) && ((sw_oh & taken) == '0)) begin
            hmove_d       = sw_sync;
            hmove_valid_d = 1'b1;
            state_d       = ISSUE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        human_d = human_q | sq_onehot(hmove_q);
        if ((human_d | comp_q) == FULL_BOARD) begin
          state_d     = DONE;
          game_over_d = 1'b1;
          draw_d      = 1'b1;
        end else begin
          state_d = WAIT_C;
        end
      end
      WAIT_C: begin
        if ((cmove_oh & taken) == '0) begin
          comp_d = comp_q | cmove_oh;
        end
        if (bus.win) begin
          state_d     = DONE;
          game_over_d = 1'b1;
          comp_won_d  = 1'b1;
        end else if ((human_q | comp_d) == FULL_BOARD) begin
          state_d     = DONE;
          game_over_d = 1'b1;
          draw_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      hmove_q       <= NO_MOVE;
      hmove_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      human_q       <= '0;
      comp_q        <= COMP_INIT;
      game_over_q   <= 1'b0;
      comp_won_q    <= 1'b0;
      draw_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hmove_q       <= hmove_d;
      hmove_valid_q <= hmove_valid_d;
      illegal_q     <= illegal_d;
      human_q       <= human_d;
      comp_q        <= comp_d;
      game_over_q   <= game_over_d;
      comp_won_q    <= comp_won_d;
      draw_q        <= draw_d;
    end
  end

  assign bus.hMove      = hmove_q;
  assign bus.hMoveValid = hmove_valid_q;
  assign bus.illegal    = illegal_q;
  assign bus.humanBoard = human_q;
  assign bus.compBoard  = comp_q;
  assign bus.gameOver   = game_over_q;
  assign bus.compWon    = comp_won_q;
  assign bus.draw       = draw_q;

endmodule

`default_nettype wire
